// File: rtl/sd_pixel_loader_pkg.sv
// Shared types and helpers for the SD-card BMP pixel loader: FSM states,
// pixel-format codes and the 24-bit to 16-bit colour reduction.
package sd_pixel_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKIP,
        ST_PACK,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic MODE_565 = 1'b0;
    localparam logic MODE_888 = 1'b1;

    // Truncating reduction, no rounding: keep the top bits of each channel.
    function automatic logic [15:0] rgb888_to_565(input logic [7:0] b,
                                                  input logic [7:0] g,
                                                  input logic [7:0] r);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/sd_pixel_loader_pix_fifo.sv
// Small synchronous FIFO for assembled pixels; DEPTH must be a power of two.
// pop_data reads zero while empty so the output port is clean after reset.
module pix_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array has no reset; only pointers and count do, and
    // empty masks pop_data, so stale entries can never reach the output.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sd_pixel_loader.sv
// Streams a BMP file from SD: drops the header, packs RGB565 or BGR888 bytes
// into RGB565 pixels and hands them to the SDRAM writer through pix_fifo.
module sd_pixel_loader
    import sd_pixel_loader_pkg::*;
#(
    parameter int HDR_BYTES    = 54,
    parameter int FRAME_PIXELS = 786432,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              mode,
    input  logic                              in_valid,
    input  logic [7:0]                        in_data,
    output logic                              in_ready,
    output logic                              out_valid,
    output logic [15:0]                       out_data,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(FRAME_PIXELS+1)-1:0] pix_cnt
);

    localparam int HDR_W = (HDR_BYTES > 0) ? $clog2(HDR_BYTES+1) : 1;
    localparam int PIX_W = $clog2(FRAME_PIXELS+1);
    localparam int FCW   = $clog2(FIFO_DEPTH+1);
    localparam logic [HDR_W-1:0] HDR_MAX = HDR_W'(HDR_BYTES);
    localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(FRAME_PIXELS);

    state_t           state;
    state_t           state_next;
    logic             mode_q;
    logic [1:0]       byte_idx;
    logic [7:0]       byte0;
    logic [7:0]       byte1;
    logic [HDR_W-1:0] hdr_cnt;
    logic [PIX_W-1:0] pix_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;
    logic             accept;
    logic             start_ok;
    logic             last_byte;
    logic             hdr_last;
    logic             frame_last;
    logic             push;
    logic [15:0]      push_data;

    // Ready comes from registered state only, so a pop in the same cycle
    // never opens room in a full FIFO.
    assign in_ready   = (state == ST_SKIP) || ((state == ST_PACK) && !fifo_full);
    assign accept     = in_valid && in_ready;
    assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_byte  = (mode_q == MODE_565) ? (byte_idx == 2'd1) : (byte_idx == 2'd2);
    assign hdr_last   = (int'(hdr_cnt) == HDR_BYTES - 1);
    assign frame_last = (int'(pix_q) == FRAME_PIXELS - 1);
    assign push       = accept && (state == ST_PACK) && last_byte;
    assign push_data  = (mode_q == MODE_565) ? {in_data, byte0}
                                             : rgb888_to_565(byte0, byte1, in_data);

    // NOTE: every sequential process uses non-blocking assignments so all
    // registers see the same pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: defaults at the top keep every output assigned on every path,
    // which is what stops a latch from being inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (start) state_next = (HDR_BYTES == 0) ? ST_PACK : ST_SKIP;
            end
            ST_SKIP: begin
                busy = 1'b1;
                if (accept && hdr_last) state_next = ST_PACK;
            end
            ST_PACK: begin
                busy = 1'b1;
                if (push && frame_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (fifo_count == '0) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_565;
            byte_idx <= '0;
            byte0    <= '0;
            byte1    <= '0;
            hdr_cnt  <= '0;
            pix_q    <= '0;
        end else if (start_ok) begin
            mode_q   <= mode;
            byte_idx <= '0;
            byte0    <= '0;
            byte1    <= '0;
            hdr_cnt  <= '0;
            pix_q    <= '0;
        end else if (accept) begin
            if (state == ST_SKIP) begin
                if (hdr_cnt != HDR_MAX) hdr_cnt <= hdr_cnt + 1'b1;
            end else begin
                case (byte_idx)
                    2'd0:    byte0 <= in_data;
                    2'd1:    byte1 <= in_data;
                    default: ;
                endcase
                byte_idx <= last_byte ? 2'd0 : byte_idx + 2'd1;
                if (last_byte && (pix_q != PIX_MAX)) pix_q <= pix_q + 1'b1;
            end
        end
    end

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign pix_cnt   = pix_q;

endmodule

// File: tb/tb_sd_pixel_loader.sv
// Bench for sd_pixel_loader: a small-frame instance for directed corners and a
// 64-pixel instance for randomized traffic, both fed from the same stimulus.
module tb_sd_pixel_loader;

    localparam int HDR = 54;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        s_in_ready, s_out_valid, s_busy, s_done;
    logic [15:0] s_out_data;
    logic [2:0]  s_pix_cnt;
    logic        l_in_ready, l_out_valid, l_busy, l_done;
    logic [15:0] l_out_data;
    logic [6:0]  l_pix_cnt;

    sd_pixel_loader #(.HDR_BYTES(HDR), .FRAME_PIXELS(4), .FIFO_DEPTH(2)) dut_s (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
        .busy(s_busy), .done(s_done), .pix_cnt(s_pix_cnt)
    );

    sd_pixel_loader #(.HDR_BYTES(HDR), .FRAME_PIXELS(64), .FIFO_DEPTH(4)) dut_l (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(l_in_ready),
        .out_valid(l_out_valid), .out_data(l_out_data), .out_ready(out_ready),
        .busy(l_busy), .done(l_done), .pix_cnt(l_pix_cnt)
    );

    always #5 clk = ~clk;

    // sel picks which instance the tasks and the output monitor observe.
    logic        sel = 1'b0;
    logic        rdy, ov, bz, dn;
    logic [15:0] od;
    int          pc;

    always_comb begin
        rdy = sel ? l_in_ready  : s_in_ready;
        ov  = sel ? l_out_valid : s_out_valid;
        od  = sel ? l_out_data  : s_out_data;
        bz  = sel ? l_busy      : s_busy;
        dn  = sel ? l_done      : s_done;
        pc  = sel ? int'(l_pix_cnt) : int'(s_pix_cnt);
    end

    int          total = 0;
    int          bad   = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic        rand_ready = 1'b0;

    typedef struct {
        logic       m;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference pixel from the file-format rules, in plain arithmetic.
    function automatic logic [15:0] model_px(input logic m, input logic [7:0] b0,
                                             input logic [7:0] b1, input logic [7:0] b2);
        int v;
        if (!m) v = int'(b1) * 256 + int'(b0);
        else    v = (int'(b2) / 8) * 2048 + (int'(b1) / 4) * 32 + int'(b0) / 8;
        return 16'(v);
    endfunction

    // Transfers are observed on the falling edge; the pop happens on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(ov), 32'd1);
                check("hold_data", 32'(od), 32'(hold_d));
            end
            if (ov && out_ready) got_q.push_back(od);
            hold_v = ov && !out_ready;
            hold_d = od;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!rdy && n < 500) begin
            tick();
            n++;
        end
        if (!rdy) check("send_timeout", 32'(rdy), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic m, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        if (m) send_byte(b2);
    endtask

    task automatic send_hdr(input bit gaps);
        for (int i = 0; i < HDR; i++) begin
            if (gaps) gap($urandom_range(0, 2));
            send_byte(8'(i));
        end
    endtask

    // Mode is flipped after the pulse to show only the start-cycle value counts.
    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = ~m;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!dn && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", 32'(dn), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({tag, "_count"}, 32'(got_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_q.size()) check($sformatf("%s_px%0d", tag, k), 32'(got_q[k]), 32'(e[k]));
        end
        check({tag, "_busy"}, 32'(bz), 32'd0);
        check({tag, "_done"}, 32'(dn), 32'd1);
        check({tag, "_in_ready"}, 32'(rdy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 8'h34, 8'h12, 8'h00, 16'h1234};
        vecs[1] = '{1'b0, 8'hFF, 8'h00, 8'h00, 16'h00FF};
        vecs[2] = '{1'b0, 8'h00, 8'hFF, 8'h00, 16'hFF00};
        vecs[3] = '{1'b0, 8'hA5, 8'h5A, 8'h00, 16'h5AA5};
        vecs[4] = '{1'b1, 8'hFF, 8'h80, 8'h10, 16'h141F};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 16'h0000};
        vecs[6] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF};
        vecs[7] = '{1'b1, 8'h08, 8'h04, 8'h08, 16'h0821};

        rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 32'(rdy), 32'd0);
        check("rst_out_valid", 32'(ov), 32'd0);
        check("rst_out_data", 32'(od), 32'd0);
        check("rst_busy", 32'(bz), 32'd0);
        check("rst_done", 32'(dn), 32'd0);
        check("rst_pix_cnt", 32'(pc), 32'd0);
        rst = 1'b0;
        tick();

        in_valid = 1'b1; in_data = 8'hAA;
        repeat (3) tick();
        check("idle_in_ready", 32'(rdy), 32'd0);
        check("idle_busy", 32'(bz), 32'd0);
        in_valid = 1'b0;

        // Table-driven frames: four RGB565 pixels, then four BGR888 pixels.
        for (int f = 0; f < 2; f++) begin
            got_q.delete();
            pulse_start(vecs[f*4].m);
            check("start_busy", 32'(bz), 32'd1);
            send_hdr(1'b0);
            check("hdr_no_output", 32'(got_q.size()), 32'd0);
            check("hdr_out_valid", 32'(ov), 32'd0);
            check("hdr_pix_cnt", 32'(pc), 32'd0);
            for (int k = 0; k < 4; k++)
                send_pixel(vecs[f*4+k].m, vecs[f*4+k].b0, vecs[f*4+k].b1, vecs[f*4+k].b2);
            wait_done(100);
            check("frame_count", 32'(got_q.size()), 32'd4);
            for (int k = 0; k < 4; k++) begin
                if (k < got_q.size())
                    check($sformatf("vec%0d", f*4+k), 32'(got_q[k]), 32'(vecs[f*4+k].exp));
            end
            check("frame_pix_cnt", 32'(pc), 32'd4);
            check("frame_busy", 32'(bz), 32'd0);
        end

        // Backpressure: a 2-deep FIFO stops intake after two pixels.
        got_q.delete();
        out_ready = 1'b0;
        pulse_start(1'b0);
        send_hdr(1'b0);
        send_pixel(1'b0, 8'h11, 8'h22, 8'h00);
        send_pixel(1'b0, 8'h33, 8'h44, 8'h00);
        in_valid = 1'b1; in_data = 8'h55;
        repeat (4) tick();
        check("bp_in_ready", 32'(rdy), 32'd0);
        check("bp_pix_cnt", 32'(pc), 32'd2);
        check("bp_out_valid", 32'(ov), 32'd1);
        check("bp_out_data", 32'(od), 32'h2211);
        check("bp_no_pop", 32'(got_q.size()), 32'd0);
        out_ready = 1'b1;
        send_byte(8'h55);
        send_byte(8'h66);
        send_pixel(1'b0, 8'h77, 8'h88, 8'h00);
        wait_done(100);
        check_frame("bp", 16'h2211, 16'h4433, 16'h6655, 16'h8877);

        // Start mid-PACK is ignored; start after done restarts the count.
        got_q.delete();
        pulse_start(1'b0);
        send_hdr(1'b0);
        send_pixel(1'b0, 8'h01, 8'h02, 8'h00);
        pulse_start(1'b1);
        check("midstart_pix_cnt", 32'(pc), 32'd1);
        check("midstart_busy", 32'(bz), 32'd1);
        send_pixel(1'b0, 8'h03, 8'h04, 8'h00);
        send_pixel(1'b0, 8'h05, 8'h06, 8'h00);
        send_pixel(1'b0, 8'h07, 8'h08, 8'h00);
        wait_done(100);
        check_frame("midstart", 16'h0201, 16'h0403, 16'h0605, 16'h0807);
        pulse_start(1'b0);
        check("restart_pix_cnt", 32'(pc), 32'd0);
        check("restart_done", 32'(dn), 32'd0);
        check("restart_busy", 32'(bz), 32'd1);

        // Reset mid-frame with one buffered pixel and a half-built one.
        out_ready = 1'b0;
        send_hdr(1'b0);
        send_pixel(1'b0, 8'hAB, 8'hCD, 8'h00);
        send_byte(8'hEE);
        tick();
        check("prerst_out_valid", 32'(ov), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 32'(ov), 32'd0);
        check("midrst_pix_cnt", 32'(pc), 32'd0);
        check("midrst_busy", 32'(bz), 32'd0);
        check("midrst_in_ready", 32'(rdy), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("postrst_out_valid", 32'(ov), 32'd0);
        got_q.delete();
        pulse_start(1'b0);
        send_hdr(1'b0);
        send_pixel(1'b0, 8'h34, 8'h12, 8'h00);
        send_pixel(1'b0, 8'hBC, 8'h9A, 8'h00);
        send_pixel(1'b0, 8'hF0, 8'hDE, 8'h00);
        send_pixel(1'b0, 8'h01, 8'h00, 8'h00);
        wait_done(100);
        check_frame("fresh", 16'h1234, 16'h9ABC, 16'hDEF0, 16'h0001);

        // Randomized BGR888 frame of 64 pixels with gaps on both sides.
        rst = 1'b1;
        sel = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        got_q.delete();
        exp_q.delete();
        rand_ready = 1'b1;
        pulse_start(1'b1);
        send_hdr(1'b1);
        for (int p = 0; p < 64; p++) begin
            logic [7:0] b, g, r;
            b = 8'($urandom);
            g = 8'($urandom);
            r = 8'($urandom);
            exp_q.push_back(model_px(1'b1, b, g, r));
            gap($urandom_range(0, 3));
            send_byte(b);
            gap($urandom_range(0, 3));
            send_byte(g);
            gap($urandom_range(0, 3));
            send_byte(r);
        end
        wait_done(2000);
        rand_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (5) tick();
        check("rand_count", 32'(got_q.size()), 32'd64);
        for (int i = 0; i < 64; i++) begin
            if (i < got_q.size()) check($sformatf("rand_px%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("rand_pix_cnt", 32'(pc), 32'd64);
        check("rand_busy", 32'(bz), 32'd0);
        check("rand_done", 32'(dn), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
